// File: rtl/cipher_iter.sv
// cipher_iter: iterative AES encryption core (AES-128/192/256).
// One shared round datapath is reused for every round. The key schedule is
// supplied pre-expanded on w and is read live, never stored.
//
// Parameters
//   Nk            key length in 32-bit words (4, 6 or 8)
//   Nr            round count, must equal Nk+6
// Ports
//   clk           clock, all state updates on the rising edge
//   rst           synchronous active-high reset
//   start         begin encrypting state_in (accepted only when idle)
//   state_in      128-bit plaintext, byte 0 in bits [127:120]
//   w             expanded key, round key i at w[128*i +: 128]
//   busy          high while a block is in flight
//   done          one-cycle pulse when Encrypted_Msg is updated
//   Encrypted_Msg registered ciphertext, held until the next done
module cipher_iter #(
  parameter int Nk = 4,
  parameter int Nr = 10
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [127:0]          state_in,
  input  logic [128*(Nr+1)-1:0] w,
  output logic                  busy,
  output logic                  done,
  output logic [127:0]          Encrypted_Msg
);

  if (!((Nk == 4 || Nk == 6 || Nk == 8) && (Nr == Nk + 6))) begin : g_bad_params
    $error("cipher_iter: illegal parameter pair Nk=%0d Nr=%0d", Nk, Nr);
  end

  localparam int CntW = $clog2(Nr + 1);

  // Byte view of a block: FIPS byte k lives at element [15-k].
  typedef logic [15:0][7:0] blk_t;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    LAST
  } state_t;

  // S-box stored so that sbox(x) sits at element [255-x], i.e. SBOX[~x].
  localparam logic [255:0][7:0] SBOX = {
    128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
  };

  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  state_t          state;
  logic [CntW-1:0] cnt;
  blk_t            st;
  blk_t            sb, sr, mc, ark_in, round_out;
  logic [127:0]    rk;
  logic [127:0]    round_key [Nr+1];

  for (genvar i = 0; i <= Nr; i++) begin : g_round_key
    assign round_key[i] = w[128*i +: 128];
  end

  // SubBytes
  for (genvar i = 0; i < 16; i++) begin : g_sub_bytes
    assign sb[i] = SBOX[~st[i]];
  end

  // ShiftRows: row r of column c takes row r of column (c+r) mod 4.
  for (genvar c = 0; c < 4; c++) begin : g_shift_col
    for (genvar r = 0; r < 4; r++) begin : g_shift_row
      assign sr[15-(r+4*c)] = sb[15-(r+4*((c+r)%4))];
    end
  end

  // MixColumns
  for (genvar c = 0; c < 4; c++) begin : g_mix_col
    logic [7:0] a0, a1, a2, a3;
    assign a0 = sr[15-4*c];
    assign a1 = sr[14-4*c];
    assign a2 = sr[13-4*c];
    assign a3 = sr[12-4*c];
    assign mc[15-4*c] = xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3;
    assign mc[14-4*c] = a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3;
    assign mc[13-4*c] = a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3;
    assign mc[12-4*c] = xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3);
  end

  // AddRoundKey: the final round bypasses MixColumns. In LAST, cnt has
  // already advanced to Nr, so the same key index serves every round.
  assign rk        = round_key[cnt];
  assign ark_in    = (state == LAST) ? sr : mc;
  assign round_out = ark_in ^ rk;

  // NOTE: non-blocking assignments throughout, so every register samples the
  // pre-edge values of the others regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      // NOTE: the datapath registers are reset too, so the ciphertext port
      // reads zero after reset rather than a stale block.
      state         <= IDLE;
      cnt           <= '0;
      st            <= '0;
      busy          <= 1'b0;
      done          <= 1'b0;
      Encrypted_Msg <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            st    <= state_in ^ round_key[0];
            cnt   <= CntW'(1);
            busy  <= 1'b1;
            state <= RUN;
          end
        end
        RUN: begin
          st  <= round_out;
          cnt <= cnt + CntW'(1);
          if (cnt == CntW'(Nr - 1)) state <= LAST;
        end
        LAST: begin
          Encrypted_Msg <= round_out;
          done          <= 1'b1;
          busy          <= 1'b0;
          state         <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_cipher_iter.sv
// Directed bench for cipher_iter: FIPS-197 vectors for all three key sizes,
// latency/busy/done timing, back-to-back blocks, start held while busy,
// and reset abort. The key schedule is expanded here from an S-box derived
// arithmetically (GF(2^8) inverse + affine map).
module tb_cipher_iter;

  localparam logic [127:0] PT_B   = 128'h3243f6a8885a308d313198a2e0370734;
  localparam logic [127:0] KEY_B  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] CT_B   = 128'h3925841d02dc09fbdc118597196a0b32;
  localparam logic [127:0] PT_C   = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] KEY_C  = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] CT_C   = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [191:0] KEY_C6 = 192'h000102030405060708090a0b0c0d0e0f1011121314151617;
  localparam logic [127:0] CT_C6  = 128'hdda97ca4864cdfe06eaf70a0ec0d7191;
  localparam logic [255:0] KEY_C8 =
    256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;
  localparam logic [127:0] CT_C8  = 128'h8ea2b7ca516745bfeafc49904b496089;

  logic          clk;
  logic          rst;
  logic          start;
  logic [127:0]  state_in;
  logic [1407:0] w128;
  logic [1663:0] w192;
  logic [1919:0] w256;
  logic          start128, start192, start256;
  logic          busy128, busy192, busy256;
  logic          done128, done192, done256;
  logic [127:0]  ct128, ct192, ct256;

  int            sel;
  logic          busy_m, done_m;
  logic [127:0]  ct_m;

  int n_tests = 0;
  int n_fail  = 0;

  logic [7:0] sbox [256];

  cipher_iter #(.Nk(4), .Nr(10)) dut128 (
    .clk(clk), .rst(rst), .start(start128), .state_in(state_in), .w(w128),
    .busy(busy128), .done(done128), .Encrypted_Msg(ct128)
  );
  cipher_iter #(.Nk(6), .Nr(12)) dut192 (
    .clk(clk), .rst(rst), .start(start192), .state_in(state_in), .w(w192),
    .busy(busy192), .done(done192), .Encrypted_Msg(ct192)
  );
  cipher_iter #(.Nk(8), .Nr(14)) dut256 (
    .clk(clk), .rst(rst), .start(start256), .state_in(state_in), .w(w256),
    .busy(busy256), .done(done256), .Encrypted_Msg(ct256)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Route the shared start to the selected instance and observe only it.
  always_comb begin
    start128 = start && (sel == 0);
    start192 = start && (sel == 1);
    start256 = start && (sel == 2);
    busy_m   = busy128;
    done_m   = done128;
    ct_m     = ct128;
    if (sel == 1) begin
      busy_m = busy192;
      done_m = done192;
      ct_m   = ct192;
    end else if (sel == 2) begin
      busy_m = busy256;
      done_m = done256;
      ct_m   = ct256;
    end
  end

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // After tick() the bench sits 1 time unit into the next cycle.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [7:0] xt(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p, aa, bb;
    p = 8'h00;
    aa = a;
    bb = b;
    for (int i = 0; i < 8; i++) begin
      if (bb[0]) p = p ^ aa;
      aa = xt(aa);
      bb = bb >> 1;
    end
    return p;
  endfunction

  task automatic build_sbox();
    logic [7:0] x, y, inv;
    for (int i = 0; i < 256; i++) begin
      x = 8'(i);
      inv = 8'h00;
      for (int j = 1; j < 256; j++) begin
        y = 8'(j);
        if (x != 8'h00 && gmul(x, y) == 8'h01) inv = y;
      end
      sbox[x] = inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]}
                    ^ {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
    end
  endtask

  function automatic logic [31:0] sub_word(input logic [31:0] t);
    return {sbox[t[31:24]], sbox[t[23:16]], sbox[t[15:8]], sbox[t[7:0]]};
  endfunction

  // Expand a left-aligned key of nk words and drive the matching w bus.
  task automatic load_w(input logic [255:0] key, input int nk);
    logic [31:0]   ks[$];
    logic [31:0]   t;
    logic [7:0]    rcon;
    logic [255:0]  k;
    logic [1919:0] acc;
    int            nr;
    nr   = nk + 6;
    k    = key;
    rcon = 8'h01;
    acc  = '0;
    for (int i = 0; i < nk; i++) begin
      ks.push_back(k[255:224]);
      k = k << 32;
    end
    for (int i = nk; i < 4 * (nr + 1); i++) begin
      t = ks[i-1];
      if (i % nk == 0) begin
        t = sub_word({t[23:0], t[31:24]}) ^ {rcon, 24'h0};
        rcon = xt(rcon);
      end else if (nk == 8 && i % nk == 4) begin
        t = sub_word(t);
      end
      ks.push_back(ks[i-nk] ^ t);
    end
    for (int i = nr; i >= 0; i--)
      acc = {acc[1791:0], ks[4*i], ks[4*i+1], ks[4*i+2], ks[4*i+3]};
    case (nk)
      4:       w128 = acc[1407:0];
      6:       w192 = acc[1663:0];
      default: w256 = acc;
    endcase
  endtask

  // One block on the selected instance, start in cycle 0. busy must cover
  // cycles 1..nr and done must pulse in cycle nr+1 only.
  task automatic run_block(input string tag, input int nr, input logic [127:0] pt,
                           input logic [127:0] exp_ct);
    logic [31:0]  bpat, dpat;
    logic [127:0] ct;
    bpat = '0;
    dpat = '0;
    ct   = '0;
    state_in = pt;
    start    = 1'b1;
    for (int c = 1; c <= nr + 2; c++) begin
      tick();
      start = 1'b0;
      if (busy_m) bpat = bpat | (32'(1) << c);
      if (done_m) begin
        dpat = dpat | (32'(1) << c);
        ct   = ct_m;
      end
    end
    check($sformatf("%s busy cycles", tag), 128'(bpat), 128'((32'(1) << (nr + 1)) - 32'(2)));
    check($sformatf("%s done cycles", tag), 128'(dpat), 128'(32'(1) << (nr + 1)));
    check($sformatf("%s ciphertext", tag), ct, exp_ct);
  endtask

  initial begin
    logic [31:0]  dpat;
    logic [127:0] ct_a, ct_b;
    int           hold_err;

    rst      = 1'b1;
    start    = 1'b0;
    sel      = 0;
    state_in = '0;
    w128     = '0;
    w192     = '0;
    w256     = '0;
    build_sbox();

    // Reset state of all three instances.
    tick();
    tick();
    check("reset flags", 128'({busy128, done128, busy192, done192, busy256, done256}), 128'h0);
    check("reset ct128", ct128, 128'h0);
    check("reset ct192", ct192, 128'h0);
    check("reset ct256", ct256, 128'h0);
    rst = 1'b0;
    tick();

    // AES-128, FIPS-197 Appendix B.
    load_w({KEY_B, 128'h0}, 4);
    run_block("aes128 appB", 10, PT_B, CT_B);

    // Back-to-back: second start lands in the first block's done cycle.
    dpat     = '0;
    hold_err = 0;
    ct_a     = '0;
    ct_b     = '0;
    state_in = PT_B;
    start    = 1'b1;
    for (int c = 1; c <= 22; c++) begin
      tick();
      start = 1'b0;
      if (done128) dpat = dpat | (32'(1) << c);
      if (c == 11) begin
        ct_a = ct128;
        load_w({KEY_C, 128'h0}, 4);
        state_in = PT_C;
        start    = 1'b1;
      end
      if (c >= 12 && c <= 21 && ct128 !== CT_B) hold_err++;
      if (c == 22) ct_b = ct128;
    end
    check("b2b done cycles", 128'(dpat), 128'((32'(1) << 11) | (32'(1) << 22)));
    check("b2b first ct", ct_a, CT_B);
    check("b2b hold errors", 128'(hold_err), 128'h0);
    check("b2b second ct", ct_b, CT_C);

    // start held high for the whole block, state_in changed in cycle 3.
    load_w({KEY_B, 128'h0}, 4);
    dpat     = '0;
    ct_a     = '0;
    state_in = PT_B;
    start    = 1'b1;
    for (int c = 1; c <= 13; c++) begin
      tick();
      if (c == 3) state_in = PT_C;
      if (c == 11) start = 1'b0;
      if (done128) begin
        dpat = dpat | (32'(1) << c);
        ct_a = ct128;
      end
    end
    check("held done cycles", 128'(dpat), 128'(32'(1) << 11));
    check("held ct", ct_a, CT_B);
    check("held idle busy", 128'(busy128), 128'h0);

    // Reset pulsed in cycle 5 aborts the block.
    dpat     = '0;
    state_in = PT_B;
    start    = 1'b1;
    for (int c = 1; c <= 14; c++) begin
      tick();
      start = 1'b0;
      if (c == 5) rst = 1'b1;
      if (c == 6) begin
        rst = 1'b0;
        check("abort busy", 128'(busy128), 128'h0);
        check("abort ct", ct128, 128'h0);
      end
      if (done128) dpat = dpat | (32'(1) << c);
    end
    check("abort no done", 128'(dpat), 128'h0);
    load_w({KEY_C, 128'h0}, 4);
    run_block("after abort", 10, PT_C, CT_C);

    // AES-192 and AES-256, FIPS-197 Appendix C.
    load_w({KEY_C6, 64'h0}, 6);
    sel = 1;
    run_block("aes192", 12, PT_C, CT_C6);
    load_w(KEY_C8, 8);
    sel = 2;
    run_block("aes256", 14, PT_C, CT_C8);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/cipher_iter.md
CIPHER_ITER -- requirements
Module: cipher_iter

Interface
- REQ-001 SHALL have parameter Nk, default 4: key length in 32-bit words; legal values 4, 6, 8 (AES-128/192/256).
- REQ-002 SHALL have parameter Nr, default 10: round count; the only legal value is Nk+6.
- REQ-003 SHALL have port clk, input, 1: single clock; all state updates on its rising edge.
- REQ-004 SHALL have port rst, input, 1: reset; synchronous and active-high.
- REQ-005 SHALL have port start, input, 1: request to encrypt state_in; honoured only in IDLE.
- REQ-006 SHALL have port state_in, input, 128: plaintext block; bits [127:120] = byte 0, FIPS-197 column-major order.
- REQ-007 SHALL have port w, input, 128*(Nr+1): expanded key schedule; round key i = w[128*i +: 128], same byte order as state_in.
- REQ-008 SHALL have port busy, output, 1: high while a block is in flight.
- REQ-009 SHALL have port done, output, 1: one-cycle pulse; Encrypted_Msg is valid.
- REQ-010 SHALL have port Encrypted_Msg, output, 128: ciphertext, registered, held until the next done.

Function
- REQ-011 SHALL implement an FSM with states IDLE, RUN and LAST, and a round counter of width clog2(Nr+1).
- REQ-012 IDLE: start=1 at an edge SHALL load st <= state_in ^ w[0], set cnt <= 1 and go to RUN.
- REQ-013 RUN: each edge SHALL apply st <= AddRoundKey(MixColumns(ShiftRows(SubBytes(st))), w[cnt]) and increment cnt.
- REQ-014 RUN SHALL go to LAST on the edge where cnt == Nr-1.
- REQ-015 LAST: the edge SHALL load Encrypted_Msg <= AddRoundKey(ShiftRows(SubBytes(st)), w[Nr]), with no MixColumns.
- REQ-016 On that same LAST edge, done SHALL be set to 1 and the FSM SHALL go to IDLE.
- REQ-017 Round logic SHALL be one shared combinational round datapath, time-multiplexed across rounds and built from the team's SubBytes, ShiftRows, MixColumns and AddRoundKey blocks; it SHALL NOT be unrolled.
- REQ-018 Latency: start sampled high at the edge ending cycle 0 SHALL give busy=1 in cycles 1..Nr and done=1 in cycle Nr+1 only (cycle 11 for Nr=10, 13 for Nr=12, 15 for Nr=14).
- REQ-019 done SHALL be high for exactly one cycle per accepted start and low at all other times.
- REQ-020 Throughput: a start in the done cycle SHALL be accepted, giving back-to-back blocks every Nr+1 cycles.
- REQ-021 start while busy=1 SHALL be ignored, with no effect on st, cnt or the outputs.
- REQ-022 state_in SHALL be sampled only at the accepting edge; later changes SHALL have no effect.
- REQ-023 w SHALL NOT be latched; the driver holds w stable from acceptance through the LAST edge.
- REQ-024 Encrypted_Msg SHALL change only on the LAST edge.
- REQ-025 Encrypted_Msg SHALL hold its value through IDLE and through the next block's RUN cycles.
- REQ-026 An illegal parameter pair (Nr != Nk+6, or Nk not in {4,6,8}) SHALL stop elaboration with an error.

Reset
- REQ-027 rst=1 at an edge SHALL force the FSM to IDLE and set cnt=0, st=0, busy=0, done=0, Encrypted_Msg=0.
- REQ-028 rst SHALL take priority over start and over any in-progress round.
- REQ-029 Reset mid-operation SHALL abort the block with no done pulse.
- REQ-030 The first start after rst falls SHALL behave exactly as REQ-018.

Verification
- REQ-031 AES-128 (FIPS-197 App. B): pt 3243f6a8885a308d313198a2e0370734, key 2b7e151628aed2a6abf7158809cf4f3c -> 3925841d02dc09fbdc118597196a0b32, done in cycle 11.
- REQ-032 AES-192 (Nk=6, Nr=12): pt 00112233445566778899aabbccddeeff, key 000102...1617 -> dda97ca4864cdfe06eaf70a0ec0d7191, done in cycle 13.
- REQ-033 AES-256 (Nk=8, Nr=14): same pt, key 000102...1e1f -> 8ea2b7ca516745bfeafc49904b496089, done in cycle 15.
- REQ-034 Back-to-back (AES-128): App. B vector, then start in the done cycle with pt 00112233445566778899aabbccddeeff and key 000102...0f.
  - Required: second done 11 cycles after the first, Encrypted_Msg 69c4e0d86a7b0430d8cdb78070b4c55a.
  - Required: Encrypted_Msg holds 3925841d... until then.
- REQ-035 Start held high throughout one AES-128 block, with state_in changed in cycle 3: exactly one done; result equals the cycle-0 pt's ciphertext.
- REQ-036 Reset abort: rst pulsed in cycle 5 of a block -> no done, busy=0 and Encrypted_Msg=0 next cycle.
  - A following start yields the correct ciphertext in 11 cycles.
